// File: rtl/bpu_sram_pkg.sv
// Shared defaults and types for the BPU SRAM port controller.
package bpu_sram_pkg;
  localparam int ADDR_W     = 9;
  localparam int WAYS       = 4;
  localparam int WAY_W      = 80;
  localparam int DATA_W     = WAYS * WAY_W;
  localparam int STARVE_MAX = 8;

  typedef enum logic {CLEAR, RUN} ctrl_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WAYS-1:0]   mask;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;
endpackage

// File: rtl/bpu_sram_port_ctrl_if.sv
// Requester-side read/write handshake bundle for bpu_sram_port_ctrl.
interface bpu_sram_port_ctrl_if #(
  parameter int ADDR_W = bpu_sram_pkg::ADDR_W,
  parameter int WAYS   = bpu_sram_pkg::WAYS,
  parameter int WAY_W  = bpu_sram_pkg::WAY_W
);
  localparam int DATA_W = WAYS * WAY_W;

  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [WAYS-1:0]   w_mask;
  logic [DATA_W-1:0] w_data;

  modport master (
    output r_valid, r_addr, w_valid, w_addr, w_mask, w_data,
    input  r_ready, r_resp_valid, r_resp_data, w_ready
  );
  modport slave (
    input  r_valid, r_addr, w_valid, w_addr, w_mask, w_data,
    output r_ready, r_resp_valid, r_resp_data, w_ready
  );
endinterface

// File: rtl/bpu_sram_wbuf.sv
// One-entry write buffer: holds a pending write, counts read-starved cycles,
// and flags reads that would hit the buffered address.
module bpu_sram_wbuf #(
  parameter int ADDR_W     = bpu_sram_pkg::ADDR_W,
  parameter int WAYS       = bpu_sram_pkg::WAYS,
  parameter int WAY_W      = bpu_sram_pkg::WAY_W,
  parameter int STARVE_MAX = bpu_sram_pkg::STARVE_MAX
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [WAYS-1:0]         push_mask,
  input  logic [WAYS*WAY_W-1:0]   push_data,
  input  logic                    drain,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    vld,
  output logic [ADDR_W-1:0]       addr,
  output logic [WAYS-1:0]         mask,
  output logic [WAYS*WAY_W-1:0]   data,
  output logic                    hazard,
  output logic                    force_drain
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [WAYS-1:0]       mask;
    logic [WAYS*WAY_W-1:0] data;
  } ent_t;

  ent_t          ent_q;
  logic [CW-1:0] starve;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld    <= 1'b0;
      ent_q  <= '0;
      starve <= '0;
    end else begin
      if (push) begin
        vld   <= 1'b1;
        ent_q <= '{addr: push_addr, mask: push_mask, data: push_data};
      end else if (drain) begin
        vld <= 1'b0;
      end
      // Counts only while an entry is sitting undrained; a same-cycle refill starts fresh.
      if (!vld || drain)                 starve <= '0;
      else if (starve != CW'(STARVE_MAX)) starve <= starve + 1'b1;
    end
  end

  assign addr        = ent_q.addr;
  assign mask        = ent_q.mask;
  assign data        = ent_q.data;
  assign hazard      = vld && (rd_addr == ent_q.addr);
  assign force_drain = vld && (starve == CW'(STARVE_MAX));
endmodule

// File: rtl/bpu_sram_port_ctrl.sv
// Requester-side controller for a single-port way-masked BPU SRAM macro:
// zero-fill sweep after reset, read/write arbitration, read response.
// Define BPU_SRAM_HOLD_READ_EN to hold r_resp_data between responses.
module bpu_sram_port_ctrl #(
  parameter int ADDR_W     = bpu_sram_pkg::ADDR_W,
  parameter int WAYS       = bpu_sram_pkg::WAYS,
  parameter int WAY_W      = bpu_sram_pkg::WAY_W,
  parameter int STARVE_MAX = bpu_sram_pkg::STARVE_MAX
) (
  input  logic                  clock,
  input  logic                  reset_n,
  bpu_sram_port_ctrl_if.slave   req,
  output logic                  init_done,
  output logic [ADDR_W-1:0]     RW0_addr,
  output logic                  RW0_en,
  output logic                  RW0_wmode,
  output logic [WAYS-1:0]       RW0_wmask,
  output logic [WAYS*WAY_W-1:0] RW0_wdata,
  input  logic [WAYS*WAY_W-1:0] RW0_rdata
);
  import bpu_sram_pkg::*;
  localparam int DATA_W = WAYS * WAY_W;
  localparam int STAGES = 1;

  ctrl_state_e       state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [STAGES:1]   vld_pipe;
  logic              rd_issue, drain, push, r_rdy, w_rdy;
  logic              wb_vld, wb_hazard, wb_force;
  logic [ADDR_W-1:0] wb_addr;
  logic [WAYS-1:0]   wb_mask;
  logic [DATA_W-1:0] wb_data;
  logic              en_c, wmode_c;
  logic [ADDR_W-1:0] addr_c;
  logic [WAYS-1:0]   wmask_c;
  logic [DATA_W-1:0] wdata_c;

  bpu_sram_wbuf #(.ADDR_W(ADDR_W), .WAYS(WAYS), .WAY_W(WAY_W), .STARVE_MAX(STARVE_MAX)) u_wbuf (
    .clock(clock), .reset_n(reset_n),
    .push(push), .push_addr(req.w_addr), .push_mask(req.w_mask), .push_data(req.w_data),
    .drain(drain), .rd_addr(req.r_addr),
    .vld(wb_vld), .addr(wb_addr), .mask(wb_mask), .data(wb_data),
    .hazard(wb_hazard), .force_drain(wb_force)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      vld_pipe <= '0;
    end else begin
      state       <= state_nxt;
      vld_pipe[1] <= rd_issue;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    en_c      = 1'b0;
    wmode_c   = 1'b0;
    addr_c    = '0;
    wmask_c   = '0;
    wdata_c   = '0;
    r_rdy     = 1'b0;
    w_rdy     = 1'b0;
    rd_issue  = 1'b0;
    drain     = 1'b0;
    case (state)
      CLEAR: begin
        en_c    = 1'b1;
        wmode_c = 1'b1;
        wmask_c = '1;
        addr_c  = clr_cnt;
        if (&clr_cnt) state_nxt = RUN;
      end
      default: begin
        // Force drain beats reads; otherwise reads win and the buffer fills idle slots.
        r_rdy    = !wb_force && !wb_hazard;
        rd_issue = r_rdy && req.r_valid;
        drain    = wb_vld && !rd_issue;
        w_rdy    = !wb_vld || drain;
        if (rd_issue) begin
          en_c   = 1'b1;
          addr_c = req.r_addr;
        end else if (drain) begin
          en_c    = 1'b1;
          wmode_c = 1'b1;
          addr_c  = wb_addr;
          wmask_c = wb_mask;
          wdata_c = wb_data;
        end
      end
    endcase
  end

  // Macro stays idle while reset is held, even though the state register reads CLEAR.
  assign RW0_en    = en_c & reset_n;
  assign RW0_wmode = wmode_c & reset_n;
  assign RW0_wmask = wmask_c & {WAYS{reset_n}};
  assign RW0_addr  = addr_c;
  assign RW0_wdata = wdata_c;

  assign push             = req.w_valid && w_rdy;
  assign req.r_ready      = r_rdy;
  assign req.w_ready      = w_rdy;
  assign req.r_resp_valid = vld_pipe[STAGES];
  assign init_done        = (state == RUN);

`ifdef BPU_SRAM_HOLD_READ_EN
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               rdata_q <= '0;
    else if (vld_pipe[STAGES])  rdata_q <= RW0_rdata;
  end
  assign req.r_resp_data = vld_pipe[STAGES] ? RW0_rdata : rdata_q;
`else
  assign req.r_resp_data = RW0_rdata;
`endif
endmodule

// File: tb/tb_bpu_sram_port_ctrl.sv
// Scoreboard bench for bpu_sram_port_ctrl: macro model, shadow-memory reference, directed + random traffic.
module tb_bpu_sram_port_ctrl;
  localparam int ADDR_W = bpu_sram_pkg::ADDR_W;
  localparam int WAYS   = bpu_sram_pkg::WAYS;
  localparam int WAY_W  = bpu_sram_pkg::WAY_W;
  localparam int DATA_W = WAYS * WAY_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bpu_sram_port_ctrl_if #(.ADDR_W(ADDR_W), .WAYS(WAYS), .WAY_W(WAY_W)) req();
  logic              init_done, RW0_en, RW0_wmode;
  logic [ADDR_W-1:0] RW0_addr;
  logic [WAYS-1:0]   RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata, RW0_rdata;

  bpu_sram_port_ctrl dut (
    .clock(clock), .reset_n(reset_n), .req(req), .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input logic [WAYS-1:0] m,
                                              input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = old;
    for (int w = 0; w < WAYS; w++)
      if (m[w]) r[w*WAY_W +: WAY_W] = d[w*WAY_W +: WAY_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  // Macro model: junk contents while reset is held so the clear sweep matters.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = rnd_data();
    end else if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] = merge(mem[RW0_addr], RW0_wmask, RW0_wdata);
      else           RW0_rdata <= mem[RW0_addr];
    end
  end

  // Reference: a read sees every write accepted in earlier cycles.
  typedef struct { int due; logic [DATA_W-1:0] data; } exp_t;
  exp_t q[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
    end else begin
      if (req.r_valid && req.r_ready) q.push_back('{due: cyc + 1, data: shadow[req.r_addr]});
      if (req.w_valid && req.w_ready) shadow[req.w_addr] = merge(shadow[req.w_addr], req.w_mask, req.w_data);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (req.r_resp_valid) begin
        if (q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("resp_data", req.r_resp_data, e.data);
          chk("resp_latency", cyc, e.due);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("resp_missing", 0, 1);
      end
    end
  end

  task automatic idle_inputs();
    req.r_valid = 1'b0; req.r_addr = '0;
    req.w_valid = 1'b0; req.w_addr = '0; req.w_mask = '0; req.w_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_en", RW0_en, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_resp_valid", req.r_resp_valid, 0);
    chk("rst_ready", {req.r_ready, req.w_ready}, 0);
    reset_n = 1'b1;
    #1;
    chk("clr_start_addr", RW0_addr, 0);
    chk("clr_start_cmd", {RW0_en, RW0_wmode, RW0_wmask}, {2'b11, {WAYS{1'b1}}});
  endtask

  task automatic init_wait();
    repeat (DEPTH - 1) @(posedge clock);
    @(negedge clock);
    chk("init_done_early", init_done, 0);
    @(posedge clock);
    @(negedge clock);
    chk("init_done", init_done, 1);
    @(posedge clock); #1;
  endtask

  task automatic rd(input int a, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    req.r_valid = 1'b1;
    req.r_addr = a[ADDR_W-1:0];
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clock); acc = req.r_ready;
      @(posedge clock); #1;
      if (!acc) waits++;
    end
    if (!acc) chk("rd_timeout", 0, 1);
    req.r_valid = 1'b0;
  endtask

  task automatic wr(input int a, input logic [WAYS-1:0] m, input logic [DATA_W-1:0] d);
    logic acc;
    acc = 1'b0;
    req.w_valid = 1'b1; req.w_addr = a[ADDR_W-1:0]; req.w_mask = m; req.w_data = d;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clock); acc = req.w_ready;
      @(posedge clock); #1;
    end
    if (!acc) chk("wr_timeout", 0, 1);
    req.w_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, nwr;
    idle_inputs();
    do_reset();
    init_wait();

    for (int a = 0; a < DEPTH; a++) rd(a, w);

    wr(5, 4'b0101, '1);
    rd(5, w);
    repeat (2) @(posedge clock); #1;

    wr(7, '1, rnd_data());
    rd(7, w);
    chk("hazard_stall_cycles", w, 1);

    // Reads to other sets keep the write starved until it is forced.
    wr(9, '1, rnd_data());
    for (int i = 1; i <= 12; i++) begin
      req.r_valid = 1'b1;
      req.r_addr = ADDR_W'(10 + i);
      @(negedge clock);
      chk($sformatf("force_rready_%0d", i), req.r_ready, (i != 9));
      if (i == 9) chk("force_is_write", {RW0_en, RW0_wmode, RW0_addr}, {2'b11, ADDR_W'(9)});
      @(posedge clock); #1;
    end
    req.r_valid = 1'b0;

    nwr = 0;
    for (int i = 0; i < 16; i++) begin
      req.w_valid = 1'b1;
      req.w_addr = ADDR_W'(20 + i);
      req.w_mask = (i == 3) ? '0 : WAYS'($urandom);
      req.w_data = rnd_data();
      @(negedge clock);
      chk("b2b_w_ready", req.w_ready, 1);
      if (RW0_en && RW0_wmode) nwr++;
      @(posedge clock); #1;
    end
    req.w_valid = 1'b0;
    @(negedge clock);
    if (RW0_en && RW0_wmode) nwr++;
    chk("b2b_macro_writes", nwr, 16);
    @(posedge clock); #1;
    for (int a = 20; a < 36; a++) rd(a, w);

    for (int i = 0; i < 600; i++) begin
      req.r_valid = 1'($urandom);
      req.r_addr  = ADDR_W'($urandom_range(0, 15));
      req.w_valid = 1'($urandom);
      req.w_addr  = ADDR_W'($urandom_range(0, 15));
      req.w_mask  = WAYS'($urandom);
      req.w_data  = rnd_data();
      @(posedge clock); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clock); #1;

    // Reset with a read in flight, then again part-way through the sweep.
    req.r_valid = 1'b1; req.r_addr = 3;
    @(posedge clock); #1;
    do_reset();
    repeat (200) @(posedge clock);
    @(negedge clock);
    chk("clr_addr_200", RW0_addr, 200);
    do_reset();
    init_wait();
    rd(5, w); rd(7, w); rd(9, w); rd(20, w);
    repeat (3) @(posedge clock); #1;
    chk("sb_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
